// File: rtl/icache_refill_ctrl.sv
// I-cache line refill controller: one outstanding line fetch over a four-phase
// req/ready handshake, ending in a single-cycle fill strobe. Define REFILL_TIMEOUT_EN to bound the REQ wait.
`timescale 1ns/100ps
module icache_refill_ctrl #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned LINE_W         = 128,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              miss_valid_i,
    output logic              miss_ready_o,
    input  logic [ADDR_W-1:0] miss_addr_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ready_i,
    input  logic [LINE_W-1:0] mem_data_i,
    output logic              fill_valid_o,
    output logic [ADDR_W-1:0] fill_addr_o,
    output logic [LINE_W-1:0] fill_data_o,
    output logic              busy_o,
    output logic              refill_err_o
);

    // state     | meaning
    // S_IDLE    | accepting a miss
    // S_REQ     | mem_req held, waiting for synchronized ready
    // S_FILL    | fill_valid strobe cycle
    // S_RELEASE | mem_req low, waiting for memory to drop ready
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_FILL    = 2'd2,
        S_RELEASE = 2'd3
    } state_e;

    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'(LINE_W / 8 - 1);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_e            state_q, state_d;
    logic              rdy_meta_q, rdy_s_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              mem_req_q, mem_req_d;
    logic              fill_valid_q, fill_valid_d;
    logic              miss_ready_q, miss_ready_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              tmo_hit;

    // mem_ready comes from another clock domain
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rdy_meta_q <= 1'b0;
            rdy_s_q    <= 1'b0;
        end else begin
            rdy_meta_q <= mem_ready_i;
            rdy_s_q    <= rdy_meta_q;
        end
    end

`ifdef REFILL_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // REQ is only entered from IDLE, so clearing in IDLE clears on entry
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == S_IDLE) begin
            tmo_cnt_d = '0;
        end else if (state_q == S_REQ) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    assign tmo_hit = (state_q == S_REQ) && (tmo_cnt_d == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        line_d       = line_q;
        mem_req_d    = mem_req_q;
        fill_valid_d = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (miss_valid_i) begin
                    addr_d    = miss_addr_i & ~OFFSET_MASK;
                    mem_req_d = 1'b1;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                // a late ready still beats the timeout on the same edge
                if (rdy_s_q) begin
                    line_d       = mem_data_i;
                    mem_req_d    = 1'b0;
                    fill_valid_d = 1'b1;
                    state_d      = S_FILL;
                end else if (tmo_hit) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = S_RELEASE;
                end
            end
            S_FILL: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!rdy_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase

        miss_ready_d = (state_d == S_IDLE);
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            line_q       <= '0;
            mem_req_q    <= 1'b0;
            fill_valid_q <= 1'b0;
            miss_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            line_q       <= line_d;
            mem_req_q    <= mem_req_d;
            fill_valid_q <= fill_valid_d;
            miss_ready_q <= miss_ready_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign miss_ready_o = miss_ready_q;
    assign mem_req_o    = mem_req_q;
    assign mem_addr_o   = addr_q;
    assign fill_valid_o = fill_valid_q;
    assign fill_addr_o  = addr_q;
    assign fill_data_o  = line_q;
    assign busy_o       = busy_q;
    assign refill_err_o = err_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Randomized bench for icache_refill_ctrl: asynchronous memory model plus a
// transaction-level reference (address/data queues, edge-count timing rules).
`timescale 1ns/100ps
module tb_icache_refill_ctrl;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 128;
    localparam int TMO    = 8;

    logic              clk_i        = 1'b0;
    logic              rst_n_i      = 1'b0;
    logic              miss_valid_i = 1'b0;
    logic [ADDR_W-1:0] miss_addr_i  = '0;
    logic              mem_ready_i  = 1'b0;
    logic [LINE_W-1:0] mem_data_i   = '0;
    logic              miss_ready_o;
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              fill_valid_o;
    logic [ADDR_W-1:0] fill_addr_o;
    logic [LINE_W-1:0] fill_data_o;
    logic              busy_o;
    logic              refill_err_o;

    icache_refill_ctrl #(
        .ADDR_W         (ADDR_W),
        .LINE_W         (LINE_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .miss_valid_i (miss_valid_i),
        .miss_ready_o (miss_ready_o),
        .miss_addr_i  (miss_addr_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ready_i  (mem_ready_i),
        .mem_data_i   (mem_data_i),
        .fill_valid_o (fill_valid_o),
        .fill_addr_o  (fill_addr_o),
        .fill_data_o  (fill_data_o),
        .busy_o       (busy_o),
        .refill_err_o (refill_err_o)
    );

    initial forever #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    int ecnt     = 0;
    int low_run  = 100;
    int rdy_edge = -1;
    int req_edge = 0;
    bit wait_rdy = 1'b0;
    int fills    = 0;
    int errs     = 0;
    bit prev_req  = 1'b0;
    bit prev_fill = 1'b0;
    bit prev_err  = 1'b0;

    logic [ADDR_W-1:0] cur_addr       = '0;
    logic [ADDR_W-1:0] last_fill_addr = '0;
    logic [LINE_W-1:0] last_fill_data = '0;

    bit                mem_silent = 1'b0;
    bit                use_fixed  = 1'b0;
    int                mem_lat    = 10;
    int                mem_hold   = 0;
    logic [LINE_W-1:0] fixed_data = '0;

    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [LINE_W-1:0] exp_data_q[$];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // memory side: raises ready after a latency, holds it until req falls, then releases
    initial begin
        logic [LINE_W-1:0] d;
        forever begin
            wait (mem_req_o === 1'b1);
            if (mem_silent) begin
                wait (mem_req_o === 1'b0);
            end else begin
                #(mem_lat + 0.3);
                d = use_fixed ? fixed_data : rand_line();
                mem_data_i = d;
                exp_data_q.push_back(d);
                mem_ready_i = 1'b1;
                wait (mem_req_o === 1'b0);
                #(mem_hold + 0.3);
                mem_ready_i = 1'b0;
                mem_data_i  = rand_line();
            end
        end
    end

    // edge numbering and what mem_ready looked like at each rising edge
    initial forever begin
        @(posedge clk_i);
        ecnt++;
        if (mem_ready_i) low_run = 0;
        else low_run++;
        if (mem_ready_i && wait_rdy && rdy_edge < 0) rdy_edge = ecnt;
    end

    // transaction-level reference: order, alignment, fill timing, handshake spacing
    initial forever begin
        @(negedge clk_i);
        if (!rst_n_i) begin
            wait_rdy  = 1'b0;
            prev_req  = 1'b0;
            prev_fill = 1'b0;
            prev_err  = 1'b0;
        end else begin
            if (mem_req_o && !prev_req) begin
                if (exp_addr_q.size() == 0) begin
                    check_eq("req_unexpected", mem_req_o, 1'b0);
                end else begin
                    cur_addr = exp_addr_q.pop_front();
                    check_eq("req_addr", mem_addr_o, cur_addr);
                    check_eq("req_after_ready_low", low_run >= 4, 1'b1);
                end
                wait_rdy = 1'b1;
                rdy_edge = -1;
                req_edge = ecnt;
            end else if (mem_req_o) begin
                check_eq("req_addr_stable", mem_addr_o, cur_addr);
            end

            if (fill_valid_o) begin
                check_eq("fill_single_cycle", prev_fill, 1'b0);
                check_eq("fill_latency", ecnt, rdy_edge + 2);
                check_eq("fill_addr", fill_addr_o, cur_addr);
                if (exp_data_q.size() == 0) check_eq("fill_without_data", fill_valid_o, 1'b0);
                else check_eq("fill_data", fill_data_o, exp_data_q.pop_front());
                check_eq("fill_req_dropped", mem_req_o, 1'b0);
                last_fill_addr = fill_addr_o;
                last_fill_data = fill_data_o;
                fills++;
                wait_rdy = 1'b0;
            end else if (prev_req && !mem_req_o && !refill_err_o) begin
                check_eq("req_dropped_without_fill", mem_req_o, 1'b1);
            end

`ifdef REFILL_TIMEOUT_EN
            if (refill_err_o) begin
                check_eq("err_timing", ecnt, req_edge + TMO);
                check_eq("err_single_cycle", prev_err, 1'b0);
                check_eq("err_req_low", mem_req_o, 1'b0);
                check_eq("err_no_fill", fill_valid_o, 1'b0);
                errs++;
                wait_rdy = 1'b0;
            end
`else
            if (refill_err_o) check_eq("err_tied_low", refill_err_o, 1'b0);
`endif

            if (mem_ready_i && !mem_req_o && !fill_valid_o) check_eq("stale_ready_busy", busy_o, 1'b1);
            if (mem_req_o || fill_valid_o) check_eq("busy_active", busy_o, 1'b1);

            prev_req  = mem_req_o;
            prev_fill = fill_valid_o;
            prev_err  = refill_err_o;
        end
    end

    task automatic issue(input logic [ADDR_W-1:0] a);
        int n = 0;
        miss_valid_i = 1'b1;
        miss_addr_i  = a;
        while (!miss_ready_o && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        if (!miss_ready_o) begin
            check_eq("accept_wait_expired", miss_ready_o, 1'b1);
            miss_valid_i = 1'b0;
        end else begin
            exp_addr_q.push_back(a & ~32'hF);
            @(posedge clk_i);
            #1;
            miss_valid_i = 1'b0;
            @(negedge clk_i);
        end
    endtask

    task automatic wait_fills(input int target, input int budget);
        int n = 0;
        while (fills < target && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        if (fills < target) check_eq("fill_wait_expired", fills, target);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy_o && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        if (busy_o) check_eq("idle_wait_expired", busy_o, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got still running expected finished at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int f0;
        int n;

        // reset held with a miss pending
        rst_n_i      = 1'b0;
        miss_valid_i = 1'b1;
        miss_addr_i  = 32'hCAFE_F00D;
        repeat (3) begin
            @(negedge clk_i);
            check_eq("rst_mem_req", mem_req_o, 1'b0);
            check_eq("rst_fill_valid", fill_valid_o, 1'b0);
            check_eq("rst_busy", busy_o, 1'b0);
            check_eq("rst_refill_err", refill_err_o, 1'b0);
        end
        check_eq("rst_mem_addr", mem_addr_o, 32'h0);
        check_eq("rst_fill_addr", fill_addr_o, 32'h0);
        check_eq("rst_fill_data", fill_data_o, 128'h0);
        rst_n_i      = 1'b1;
        miss_valid_i = 1'b0;
        @(negedge clk_i);
        check_eq("post_rst_miss_ready", miss_ready_o, 1'b1);
        check_eq("post_rst_no_req", mem_req_o, 1'b0);

        // single directed refill
        use_fixed  = 1'b1;
        fixed_data = 128'hDEADBEEF_01234567_89ABCDEF_CAFEBEEF;
        mem_lat    = 15;
        mem_hold   = 3;
        issue(32'h1234_567B);
        wait_fills(1, 100);
        use_fixed = 1'b0;
        check_eq("single_fill_addr", last_fill_addr, 32'h1234_5670);
        check_eq("single_fill_data", last_fill_data, 128'hDEADBEEF_01234567_89ABCDEF_CAFEBEEF);
        wait_idle(50);

        // back-to-back: second miss held during the first refill
        mem_lat  = 23;
        mem_hold = 12;
        f0 = fills;
        issue(32'hA5A5_1238);
        issue(32'h0000_0010);
        wait_fills(f0 + 2, 200);
        check_eq("b2b_second_addr", last_fill_addr, 32'h0000_0010);
        wait_idle(50);

        // stale ready held 10 cycles past the fill with a new miss pending
        mem_lat  = 7;
        mem_hold = 100;
        f0 = fills;
        issue($urandom());
        issue($urandom());
        wait_fills(f0 + 2, 400);
        wait_idle(100);

        // randomized traffic
        f0 = fills;
        for (int i = 0; i < 24; i++) begin
            mem_lat  = $urandom_range(1, 60);
            mem_hold = $urandom_range(0, 40);
            issue($urandom());
            n = $urandom_range(0, 4);
            repeat (n) @(negedge clk_i);
        end
        wait_fills(f0 + 24, 600);
        wait_idle(100);
        check_eq("random_fill_count", fills - f0, 24);

        // memory never answers
        mem_silent = 1'b1;
        f0 = fills;
`ifdef REFILL_TIMEOUT_EN
        n = errs;
        issue(32'h0BAD_0004);
        begin
            int k = 0;
            while (errs == n && k < 40) begin
                @(negedge clk_i);
                k++;
            end
        end
        check_eq("tmo_err_count", errs, n + 1);
        check_eq("tmo_no_fill", fills, f0);
        @(negedge clk_i);
        check_eq("tmo_idle_next", busy_o, 1'b0);
        check_eq("tmo_miss_ready", miss_ready_o, 1'b1);
        check_eq("tmo_err_cleared", refill_err_o, 1'b0);
        issue(32'h7777_0008);
        repeat (4) @(negedge clk_i);
`else
        issue(32'h0BAD_0004);
        repeat (120) @(negedge clk_i);
        check_eq("no_tmo_req_held", mem_req_o, 1'b1);
        check_eq("no_tmo_busy", busy_o, 1'b1);
        check_eq("no_tmo_no_fill", fills, f0);
        check_eq("no_tmo_err_low", refill_err_o, 1'b0);
`endif

        // reset while a request is outstanding
        check_eq("pre_rst_req_high", mem_req_o, 1'b1);
        rst_n_i = 1'b0;
        @(negedge clk_i);
        check_eq("midreq_rst_req", mem_req_o, 1'b0);
        check_eq("midreq_rst_fill", fill_valid_o, 1'b0);
        check_eq("midreq_rst_busy", busy_o, 1'b0);
        check_eq("midreq_rst_addr", mem_addr_o, 32'h0);
        rst_n_i    = 1'b1;
        mem_silent = 1'b0;
        f0 = fills;
        repeat (10) @(negedge clk_i);
        check_eq("midreq_no_fill", fills, f0);
        check_eq("midreq_no_req", mem_req_o, 1'b0);
        check_eq("midreq_miss_ready", miss_ready_o, 1'b1);

        // recovery refill
        mem_lat  = 9;
        mem_hold = 5;
        issue(32'h0F0F_F0FF);
        wait_fills(f0 + 1, 100);
        check_eq("recover_fill_addr", last_fill_addr, 32'h0F0F_F0F0);
        wait_idle(50);

        check_eq("addr_queue_drained", exp_addr_q.size(), 0);
        check_eq("data_queue_drained", exp_data_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/icache_refill_ctrl.md
# icache_refill_ctrl

Miss-refill controller between the I-cache lookup stage and the backing memory model. Accepts one line-miss request at a time, issues a level-held, line-aligned request on the 128-bit memory port, captures the returned line, and writes it into the cache data/tag arrays as a single-cycle fill pulse. Enforces the four-phase return-to-zero handshake the memory side expects.

## Interface
- `ADDR_W`, 32: byte-address width.
- `LINE_W`, 128: line width in bits (16-byte line, offset bits [3:0]).
- `TIMEOUT_CYCLES`, 64: REQ-state cycle budget; only used with `REFILL_TIMEOUT_EN`.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `miss_valid`  in  1  cache reports a miss.
- `miss_ready`  out  1  controller can accept a miss.
- `miss_addr`  in  ADDR_W  missing byte address.
- `mem_req`  out  1  memory request, level-held.
- `mem_addr`  out  ADDR_W  line-aligned request address.
- `mem_ready`  in  1  memory data valid; asynchronous to `clk`.
- `mem_data`  in  LINE_W  returned line; stable while `mem_ready` high.
- `fill_valid`  out  1  one-cycle write strobe to cache arrays.
- `fill_addr`  out  ADDR_W  line-aligned fill address.
- `fill_data`  out  LINE_W  line to write.
- `busy`  out  1  state != IDLE.
- `refill_err`  out  1  one-cycle timeout pulse.

## Operation
- `mem_ready` passes through a 2-flop synchronizer (`rdy_s`); all decisions use `rdy_s`.
- States: IDLE, REQ, FILL, RELEASE.
- IDLE: `miss_ready`=1. On `miss_valid` at an edge: latch `{miss_addr[ADDR_W-1:4],4'b0}` into the address register, set `mem_req`=1, go REQ. Offset bits always zero on `mem_addr`/`fill_addr`.
- REQ: `mem_req`=1, `mem_addr` stable. On `rdy_s`=1: capture `mem_data` into line register, clear `mem_req`, go FILL.
- FILL: `fill_valid`=1 for exactly one cycle with latched address and line; go RELEASE.
- RELEASE: `mem_req`=0; stay until `rdy_s`=0, then IDLE. No new request issued while memory still shows ready.
- `miss_valid` outside IDLE ignored (`miss_ready`=0); the cache holds its miss until accepted.
- All outputs registered.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, `mem_req`=0, `mem_addr`=0, `fill_valid`=0, `fill_addr`=0, `fill_data`=0, `busy`=0, `refill_err`=0, synchronizer flops 0, timeout counter 0; `miss_ready`=1 from the first cycle after reset. Reset mid-REQ drops `mem_req` on that edge; no fill.
- Accept at edge E0 → `mem_req`/`mem_addr` valid after E0.
- `mem_ready` rising before edge Ek → `rdy_s`=1 after Ek+1 → line captured at Ek+2 → `fill_valid` high for the cycle after Ek+2.
- Minimum accept-to-fill: 3 cycles if `mem_ready` is already high (stale-ready excluded by RELEASE rule).
- `mem_ready` falling → IDLE 2–3 edges later; back-to-back refills spaced by handshake, never overlapped.
- `mem_ready` pulse shorter than one `clk` period may be missed; memory must hold ready until `mem_req` falls.

## Configuration
- `REFILL_TIMEOUT_EN` defined: counter clears on entering REQ, increments each REQ cycle; when it reaches `TIMEOUT_CYCLES` with `rdy_s`=0, clear `mem_req`, pulse `refill_err` one cycle, skip FILL, go RELEASE. `rdy_s` and timeout on the same edge: `rdy_s` wins (normal fill).
- Undefined: no counter, REQ waits indefinitely, `refill_err` tied 0.

## Test plan
- Reset: hold `rst_n`=0 3 cycles with `miss_valid`=1 → all outputs 0, `miss_ready`=1 after release, no `mem_req`.
- Single refill: `miss_addr`=0x1234_567B, memory returns 0xDEAD…BEEF after 15 ns → `mem_addr`=0x1234_5670, one `fill_valid` pulse with `fill_addr`=0x1234_5670 and matching data, `mem_req` drops same edge as capture.
- Back-to-back: second miss 0x0000_0010 held during first refill → accepted only after `mem_ready` low and IDLE; two fills, in order, no overlap.
- Stale ready: keep `mem_ready`=1 after fill for 10 cycles with new miss pending → controller stays RELEASE, `mem_req`=0 until ready falls.
- Timeout (`REFILL_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8): memory never responds → `refill_err` single pulse 8 cycles into REQ, no `fill_valid`, IDLE next cycle; without macro `mem_req` stays high 100+ cycles.
- Reset mid-REQ: assert `rst_n`=0 while `mem_req`=1 → `mem_req`=0 next edge, no fill afterward.
